axin_packet_checker: RTL and testbench
======================================

# axin_packet_checker

Synthesizable sink for the AXIN (AXI network packet) stream. It accepts packets from an AXIN source, such as a packet generator, a switch port or the 10Gb RX path, and computes byte length and Ethernet CRC-32 per packet. It classifies each packet as good, aborted, CRC-errored, runt or giant, and emits one summary record per packet on a small valid/ready report port. Running packet and error counters are also provided for bench scoreboards and for the switch's debug bus.

## Interface
Parameters:
- MIN_LEN, 64: minimum legal length in bytes, FCS included; shorter packets are runts.
- MAX_LEN, 1518: maximum legal length in bytes, FCS included; longer packets are giants.
- OPT_LFSR_STALL, 0: when 1, S_READY is additionally gated by bit 0 of a 16-bit LFSR, to exercise upstream backpressure.

Ports:
- S_AXI_ACLK, input, 1: clock.
- S_AXI_ARESET, input, 1: reset. Asynchronous, active-high.
- S_VALID, input, 1: input beat valid.
- S_READY, output, 1: input beat accepted when S_VALID && S_READY.
- S_DATA, input, 32: packet data. Byte 0 is in [7:0].
- S_BYTES, input, 2: valid bytes on a LAST beat. 0 means 4. Ignored on non-LAST beats, where all 4 bytes count.
- S_LAST, input, 1: final beat of the packet.
- S_ABORT, input, 1: source abandons the current packet. Honoured regardless of S_VALID/S_READY.
- M_VALID, output, 1: report valid.
- M_READY, input, 1: report consumer ready.
- M_LEN, output, 16: packet length in bytes, saturating at 16'hFFFF.
- M_CRC, output, 32: CRC-32 over all bytes, FCS included, complemented.
- M_STATUS, output, 4: [0] abort, [1] crc_err, [2] runt, [3] giant.
- o_pkt_count, output, 32: reports issued, saturating.
- o_err_count, output, 32: reports with any M_STATUS bit set, saturating.

## Operation
States:
- IDLE: no packet in progress.
- BODY: at least one beat of the current packet has been accepted.
- REPORT: a record is held on M_*.

Transitions:
- IDLE→BODY on an accepted beat without S_LAST.
- IDLE→REPORT on an accepted beat with S_LAST.
- BODY→REPORT on an accepted S_LAST beat, or on S_ABORT.
- REPORT→IDLE on M_VALID && M_READY.
- S_ABORT while in IDLE or REPORT is ignored. A beat presented with S_ABORT high is never accepted.

S_READY:
- S_READY = (state != REPORT) && !S_ABORT && (OPT_LFSR_STALL ? lfsr[0] : 1).
- Consequence: no new beat is accepted while a record is pending.

CRC:
- Reflected polynomial 32'hEDB88320, register initialised to 32'hFFFFFFFF at each packet start.
- Bytes are processed in order 0..n-1 within a beat, n = 4 except on LAST beats.
- M_CRC = ~register.
- crc_err = (M_CRC != 32'h2144DF1C), i.e. the register residue is not 32'hDEBB20E3.

Length and classification:
- Length accumulates 4 per non-LAST beat and n on the LAST beat, saturating in 16 bits.
- runt = len < MIN_LEN. giant = len > MAX_LEN.
- Aborted packet: abort = 1. crc_err, runt and giant are forced to 0. M_LEN and M_CRC reflect the bytes accepted so far.

Counters increment in the cycle the record is loaded, not when it is acknowledged.

## Timing
- Reset values: S_READY = 0 while reset is asserted, then per the rule above. M_VALID = 0, M_LEN = 0, M_CRC = 0, M_STATUS = 0, counters = 0, state = IDLE, CRC = 32'hFFFFFFFF, length = 0, LFSR = 16'hACE1.
- Latency: the record appears with M_VALID = 1 one cycle after the accepted LAST beat, or one cycle after the S_ABORT cycle.
- The record holds stable until accepted. A new packet's first beat can be accepted in the cycle after M_VALID && M_READY.
- Reset asserted mid-packet or mid-report: all state clears immediately and no partial record is issued.
- The LFSR steps every cycle (taps 16,14,13,11) and is free-running.

## Structure
- Package axin_pkg holds:
  - the CRC polynomial, seed and residue constants;
  - the status bit indices;
  - function crc32_byte(crc, byte).
- Sub-module axin_crc32_bytes is a combinational 1–4 byte CRC update: inputs crc, data and count, output next crc.
- The FSM, counters and LFSR live in the top module.

## Test plan
- "123456789" sent as beats 32'h34333231, 32'h38373635, then 32'h00000039 with S_BYTES = 1 and S_LAST → M_LEN = 9, M_CRC = 32'hCBF43926, M_STATUS = 4'b0110.
- 64-byte frame with a correct FCS, M_READY held high → M_STATUS = 0, M_CRC = 32'h2144DF1C, M_VALID exactly one cycle after LAST; o_pkt_count = 1, o_err_count = 0.
- Same frame with one data bit flipped → M_STATUS = 4'b0010, o_err_count = 1.
- S_ABORT after 3 beats → record in the next cycle with M_LEN = 12, M_STATUS = 4'b0001. A following good packet reports normally.
- M_READY held low for 10 cycles after a report → S_READY = 0 throughout and the record is stable. The next packet's first beat is accepted the cycle after the handshake.
- Stress: a 1600-byte packet reports giant = 1; OPT_LFSR_STALL = 1 with 1000 random packets gives counts matching the scoreboard; reset asserted mid-BODY produces no record and the counters read 0.

Source files
------------

// File: rtl/axin_pkg.sv
// Shared constants, types and the bytewise CRC-32 step for the AXIN packet checker.
package axin_pkg;

  // Reflected Ethernet CRC-32 constants.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  // Complement of the residue: what a frame with a correct FCS reports.
  localparam logic [31:0] CRC_GOOD    = ~CRC_RESIDUE;

  // Bit positions inside the report status field.
  localparam int STAT_ABORT = 0;
  localparam int STAT_CRC   = 1;
  localparam int STAT_RUNT  = 2;
  localparam int STAT_GIANT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BODY   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // One byte of the reflected CRC, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/axin_crc32_bytes.sv
// Combinational CRC-32 update over the first 1..4 bytes of a 32-bit beat.
module axin_crc32_bytes
  import axin_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  count_i,
  output logic [31:0] crc_o
);

  // Fold bytes 0..count-1 in order; bytes beyond the count leave the CRC untouched.
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < count_i) begin
        crc_o = crc32_byte(crc_o, data_i[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/axin_packet_checker.sv
// AXIN stream sink: per-packet length, CRC-32 and classification, one report per packet.
module axin_packet_checker
  import axin_pkg::*;
#(
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1518,
  parameter bit OPT_LFSR_STALL = 1'b0
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [31:0] S_DATA,
  input  logic [1:0]  S_BYTES,
  input  logic        S_LAST,
  input  logic        S_ABORT,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [15:0] M_LEN,
  output logic [31:0] M_CRC,
  output logic [3:0]  M_STATUS,
  output logic [31:0] o_pkt_count,
  output logic [31:0] o_err_count
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_base, crc_upd;
  logic [15:0] len_q, len_d, len_base, len_acc;
  logic [15:0] mlen_q, mlen_d;
  logic [31:0] mcrc_q, mcrc_d;
  logic [3:0]  mst_q, mst_d;
  logic [31:0] pkt_q, pkt_d, err_q, err_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] rec_len;
  logic [31:0] rec_crc;
  logic [2:0]  nbytes;
  logic        s_ready, accept, abort_ev, load;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [31:0] inc_sat32(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] classify(input logic aborted, input logic [15:0] len,
                                          input logic [31:0] mcrc);
    logic [3:0] st;
    st = '0;
    if (aborted) begin
      st[STAT_ABORT] = 1'b1;
    end else begin
      st[STAT_CRC]   = (mcrc != CRC_GOOD);
      st[STAT_RUNT]  = (len < MIN_L);
      st[STAT_GIANT] = (len > MAX_L);
    end
    return st;
  endfunction

  // A pending record or an abort blocks input; reset holds ready low as well.
  assign s_ready  = !S_AXI_ARESET && (state_q != ST_REPORT) && !S_ABORT &&
                    (OPT_LFSR_STALL ? lfsr_q[0] : 1'b1);
  assign accept   = S_VALID && s_ready;
  assign abort_ev = (state_q == ST_BODY) && S_ABORT;
  assign load     = (accept && S_LAST) || abort_ev;
  assign nbytes   = (S_LAST && (S_BYTES != 2'd0)) ? {1'b0, S_BYTES} : 3'd4;

  // The first beat of a packet starts from the seed regardless of leftover state.
  assign crc_base = (state_q == ST_BODY) ? crc_q : CRC_SEED;
  assign len_base = (state_q == ST_BODY) ? len_q : 16'd0;
  assign len_acc  = sat16({1'b0, len_base} + {14'd0, nbytes});
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  axin_crc32_bytes u_crc (
    .crc_i   (crc_base),
    .data_i  (S_DATA),
    .count_i (nbytes),
    .crc_o   (crc_upd)
  );

  // Next-state logic: FSM transitions, running accumulation and record capture.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    mlen_d  = mlen_q;
    mcrc_d  = mcrc_q;
    mst_d   = mst_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    rec_len = abort_ev ? len_q : len_acc;
    rec_crc = ~(abort_ev ? crc_q : crc_upd);
    case (state_q)
      ST_IDLE, ST_BODY: begin
        if (abort_ev)    state_d = ST_REPORT;
        else if (accept) state_d = S_LAST ? ST_REPORT : ST_BODY;
      end
      ST_REPORT: begin
        if (M_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept && !S_LAST) begin
      crc_d = crc_upd;
      len_d = len_acc;
    end
    if (load) begin
      crc_d  = CRC_SEED;
      len_d  = 16'd0;
      mlen_d = rec_len;
      mcrc_d = rec_crc;
      mst_d  = classify(abort_ev, rec_len, rec_crc);
      pkt_d  = inc_sat32(pkt_q);
      if (mst_d != 4'd0) err_d = inc_sat32(err_q);
    end
  end

  // State, accumulators, held record and counters.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC_SEED;
      len_q   <= 16'd0;
      mlen_q  <= 16'd0;
      mcrc_q  <= 32'd0;
      mst_q   <= 4'd0;
      pkt_q   <= 32'd0;
      err_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      mlen_q  <= mlen_d;
      mcrc_q  <= mcrc_d;
      mst_q   <= mst_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  // Free-running LFSR used only to throttle S_READY when enabled.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) lfsr_q <= 16'hACE1;
    else              lfsr_q <= lfsr_d;
  end

  assign S_READY     = s_ready;
  assign M_VALID     = (state_q == ST_REPORT);
  assign M_LEN       = mlen_q;
  assign M_CRC       = mcrc_q;
  assign M_STATUS    = mst_q;
  assign o_pkt_count = pkt_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_axin_packet_checker.sv
// Bench: directed table on an unthrottled checker, randomized packets on an LFSR-throttled one.
module tb_axin_packet_checker;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] len;
    logic [31:0] crc;
    logic [3:0]  st;
  } rec_t;
  typedef struct packed {
    int          len;
    bit          fcs;
    int          flip;
    int          ab;
    logic [15:0] elen;
    logic [3:0]  est;
    logic [31:0] ecrc;
  } row_t;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, s0_valid, s0_ready, s0_last, s0_abort, m0_valid, m0_ready;
  logic [31:0] s0_data, m0_crc, pkt0, err0;
  logic [1:0]  s0_bytes;
  logic [15:0] m0_len;
  logic [3:0]  m0_status;
  logic        rst1, s1_valid, s1_ready, s1_last, s1_abort, m1_valid, m1_ready;
  logic [31:0] s1_data, m1_crc, pkt1, err1;
  logic [1:0]  s1_bytes;
  logic [15:0] m1_len;
  logic [3:0]  m1_status;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pkt0 = 0;
  int exp_err0 = 0;
  int exp_pkt1 = 0;
  int exp_err1 = 0;
  rec_t sb1[$];

  axin_packet_checker #(.MIN_LEN(64), .MAX_LEN(1518), .OPT_LFSR_STALL(1'b0)) dut0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst0), .S_VALID(s0_valid), .S_READY(s0_ready),
    .S_DATA(s0_data), .S_BYTES(s0_bytes), .S_LAST(s0_last), .S_ABORT(s0_abort),
    .M_VALID(m0_valid), .M_READY(m0_ready), .M_LEN(m0_len), .M_CRC(m0_crc),
    .M_STATUS(m0_status), .o_pkt_count(pkt0), .o_err_count(err0));

  axin_packet_checker #(.MIN_LEN(64), .MAX_LEN(1518), .OPT_LFSR_STALL(1'b1)) dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst1), .S_VALID(s1_valid), .S_READY(s1_ready),
    .S_DATA(s1_data), .S_BYTES(s1_bytes), .S_LAST(s1_last), .S_ABORT(s1_abort),
    .M_VALID(m1_valid), .M_READY(m1_ready), .M_LEN(m1_len), .M_CRC(m1_crc),
    .M_STATUS(m1_status), .o_pkt_count(pkt1), .o_err_count(err1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference CRC, bit-serial over the message; returns the complemented register.
  function automatic logic [31:0] ref_crc(input bq_t b, input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic rec_t ref_rec(input bq_t b, input int n, input bit ab);
    rec_t r;
    r.len = (n > 65535) ? 16'hFFFF : 16'(n);
    r.crc = ref_crc(b, n);
    r.st  = 4'b0000;
    if (ab) r.st[0] = 1'b1;
    else begin
      r.st[1] = (r.crc != 32'h2144DF1C);
      r.st[2] = (n < 64);
      r.st[3] = (n > 1518);
    end
    return r;
  endfunction

  function automatic bq_t build(input int len, input bit fcs, input int flip, input bit rnd);
    bq_t b;
    logic [31:0] c;
    int p;
    p = fcs ? len - 4 : len;
    for (int i = 0; i < p; i++) b.push_back(rnd ? 8'($urandom) : 8'(i * 37 + 5));
    if (fcs) begin
      c = ref_crc(b, p);
      b.push_back(c[7:0]);
      b.push_back(c[15:8]);
      b.push_back(c[23:16]);
      b.push_back(c[31:24]);
    end
    if (flip >= 0) b[flip / 8] = b[flip / 8] ^ (8'h01 << (flip % 8));
    return b;
  endfunction

  function automatic logic [31:0] beat(input bq_t b, input int i);
    logic [31:0] d;
    d = '0;
    for (int j = 0; j < 4; j++) if (4 * i + j < b.size()) d[8*j +: 8] = b[4 * i + j];
    return d;
  endfunction

  function automatic row_t mk_row(input int len, input bit fcs, input int flip, input int ab,
                                  input logic [15:0] elen, input logic [3:0] est,
                                  input logic [31:0] ecrc);
    row_t r;
    r.len = len; r.fcs = fcs; r.flip = flip; r.ab = ab;
    r.elen = elen; r.est = est; r.ecrc = ecrc;
    return r;
  endfunction

  task automatic wait0();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = s0_ready;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL dut0 beat accept: got timeout required S_READY");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait1();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      got = s1_ready;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL dut1 beat accept: got timeout required S_READY");
    end
    @(posedge clk); #1;
  endtask

  // Sends beats start..end of b on dut0; ab>0 aborts in place of beat ab.
  task automatic send0(input bq_t b, input int ab, input int start);
    int nb;
    nb = (b.size() + 3) / 4;
    @(posedge clk); #1;
    for (int i = start; i < nb; i++) begin
      if (ab > 0 && i == ab) begin
        s0_valid = 1'b0; s0_last = 1'b0; s0_abort = 1'b1;
        @(posedge clk); #1;
        s0_abort = 1'b0;
        return;
      end
      s0_data  = beat(b, i);
      s0_last  = (i == nb - 1);
      s0_bytes = s0_last ? 2'(b.size() % 4) : 2'd0;
      s0_valid = 1'b1;
      wait0();
    end
    s0_valid = 1'b0; s0_last = 1'b0;
  endtask

  task automatic send1(input bq_t b, input int ab);
    int nb;
    nb = (b.size() + 3) / 4;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      if (ab > 0 && i == ab) begin
        s1_valid = 1'b0; s1_last = 1'b0; s1_abort = 1'b1;
        @(posedge clk); #1;
        s1_abort = 1'b0;
        return;
      end
      s1_data  = beat(b, i);
      s1_last  = (i == nb - 1);
      s1_bytes = s1_last ? 2'(b.size() % 4) : 2'($urandom);
      s1_valid = 1'b1;
      wait1();
    end
    s1_valid = 1'b0; s1_last = 1'b0;
  endtask

  // Record must be visible the cycle after the last beat/abort and gone after the handshake.
  task automatic check_rec0(input string nm, input rec_t e);
    @(negedge clk);
    check({nm, " valid"}, 64'(m0_valid), 64'd1);
    check({nm, " record"}, 64'({m0_len, m0_crc, m0_status}), 64'(e));
    exp_pkt0++;
    if (e.st != 4'd0) exp_err0++;
    check({nm, " pkt_count"}, 64'(pkt0), 64'(exp_pkt0));
    check({nm, " err_count"}, 64'(err0), 64'(exp_err0));
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, " valid drop"}, 64'(m0_valid), 64'd0);
  endtask

  task automatic drv1();
    bq_t b;
    int len, kind, nb, ab;
    bit fcs;
    for (int p = 0; p < NRAND; p++) begin
      len  = $urandom_range(1, 100);
      kind = $urandom_range(0, 3);
      fcs  = (kind == 1 || kind == 2) && len >= 5;
      b    = build(len, fcs, -1, 1'b1);
      nb   = (len + 3) / 4;
      ab   = (kind == 3 && nb >= 2) ? $urandom_range(1, nb - 1) : 0;
      sb1.push_back(ref_rec(b, (ab > 0) ? 4 * ab : len, ab > 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send1(b, ab);
    end
  endtask

  task automatic mon1();
    int got;
    rec_t e;
    got = 0;
    for (int cyc = 0; cyc < 70000 && got < NRAND; cyc++) begin
      @(posedge clk); #1;
      m1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m1_valid && m1_ready) begin
        got++;
        if (sb1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rand unexpected record: got %0h required none", m1_len);
        end else begin
          e = sb1.pop_front();
          exp_pkt1++;
          if (e.st != 4'd0) exp_err1++;
          check($sformatf("rand record %0d", got), 64'({m1_len, m1_crc, m1_status}), 64'(e));
        end
      end
    end
    check("rand records received", 64'(got), 64'(NRAND));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[11];
    bq_t  b, b2;
    rec_t e1;

    rst0 = 1'b1; s0_valid = 1'b0; s0_data = '0; s0_bytes = '0; s0_last = 1'b0;
    s0_abort = 1'b0; m0_ready = 1'b1;
    rst1 = 1'b1; s1_valid = 1'b0; s1_data = '0; s1_bytes = '0; s1_last = 1'b0;
    s1_abort = 1'b0; m1_ready = 1'b0;

    rows[0]  = mk_row(64,   1, -1, 0, 16'd64,   4'b0000, 32'h2144DF1C);
    rows[1]  = mk_row(64,   1, 10, 0, 16'd64,   4'b0010, ref_crc(build(64, 1, 10, 0), 64));
    rows[2]  = mk_row(63,   1, -1, 0, 16'd63,   4'b0100, 32'h2144DF1C);
    rows[3]  = mk_row(65,   1, -1, 0, 16'd65,   4'b0000, 32'h2144DF1C);
    rows[4]  = mk_row(1518, 1, -1, 0, 16'd1518, 4'b0000, 32'h2144DF1C);
    rows[5]  = mk_row(1519, 1, -1, 0, 16'd1519, 4'b1000, 32'h2144DF1C);
    rows[6]  = mk_row(1600, 1, -1, 0, 16'd1600, 4'b1000, 32'h2144DF1C);
    rows[7]  = mk_row(64,   1, -1, 3, 16'd12,   4'b0001, ref_crc(build(64, 1, -1, 0), 12));
    rows[8]  = mk_row(64,   1, -1, 0, 16'd64,   4'b0000, 32'h2144DF1C);
    rows[9]  = mk_row(1,    0, -1, 0, 16'd1,    4'b0110, ref_crc(build(1, 0, -1, 0), 1));
    rows[10] = mk_row(100,  1, -1, 1, 16'd4,    4'b0001, ref_crc(build(100, 1, -1, 0), 4));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset S_READY", 64'(s0_ready), 64'd0);
    check("reset M_VALID", 64'(m0_valid), 64'd0);
    check("reset record", 64'({m0_len, m0_crc, m0_status}), 64'd0);
    check("reset counters", {pkt0, err0}, 64'd0);
    check("reset dut1", 64'({s1_ready, m1_valid, pkt1}), 64'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("S_READY after reset", 64'(s0_ready), 64'd1);

    // Check string "123456789".
    b = {};
    for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
    send0(b, 0, 0);
    check_rec0("check123", {16'd9, 32'hCBF43926, 4'b0110});

    for (int r = 0; r < 11; r++) begin
      b = build(rows[r].len, rows[r].fcs, rows[r].flip, 1'b0);
      send0(b, rows[r].ab, 0);
      check_rec0($sformatf("row%0d", r), {rows[r].elen, rows[r].ecrc, rows[r].est});
    end

    // Abort outside a packet is ignored and its beat is not taken.
    @(posedge clk); #1;
    s0_abort = 1'b1; s0_valid = 1'b1; s0_last = 1'b0; s0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("idle abort S_READY", 64'(s0_ready), 64'd0);
    @(posedge clk); #1;
    s0_abort = 1'b0; s0_valid = 1'b0;
    @(negedge clk);
    check("idle abort no record", 64'(m0_valid), 64'd0);
    b = build(68, 1, -1, 0);
    send0(b, 0, 0);
    check_rec0("after idle abort", {16'd68, 32'h2144DF1C, 4'b0000});

    // Held report: input blocked and record stable; next beat taken right after handshake.
    m0_ready = 1'b0;
    b = build(8, 0, -1, 1'b1);
    e1 = ref_rec(b, 8, 1'b0);
    send0(b, 0, 0);
    exp_pkt0++; exp_err0++;
    b2 = build(68, 1, -1, 1'b1);
    s0_data = beat(b2, 0); s0_last = 1'b0; s0_bytes = 2'd0; s0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d S_READY", k), 64'(s0_ready), 64'd0);
      check($sformatf("hold%0d record", k), 64'({m0_valid, m0_len, m0_crc, m0_status}),
            64'({1'b1, e1}));
    end
    check("hold counters", {pkt0, err0}, {32'(exp_pkt0), 32'(exp_err0)});
    @(posedge clk); #1;
    m0_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-handshake S_READY", 64'(s0_ready), 64'd1);
    check("post-handshake M_VALID", 64'(m0_valid), 64'd0);
    @(posedge clk); #1;
    s0_valid = 1'b0;
    send0(b2, 0, 1);
    check_rec0("after hold", {16'd68, 32'h2144DF1C, 4'b0000});

    // Reset in the middle of a packet discards it and clears the counters.
    @(posedge clk); #1;
    b = build(64, 1, -1, 0);
    s0_data = beat(b, 0); s0_valid = 1'b1; s0_last = 1'b0;
    wait0();
    s0_data = beat(b, 1);
    wait0();
    rst0 = 1'b1; s0_valid = 1'b0;
    @(negedge clk);
    check("midreset S_READY", 64'(s0_ready), 64'd0);
    check("midreset outputs", 64'({m0_valid, m0_len, m0_status}), 64'd0);
    check("midreset counters", {pkt0, err0}, 64'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    exp_pkt0 = 0; exp_err0 = 0;
    repeat (3) @(negedge clk);
    check("midreset no record", 64'(m0_valid), 64'd0);
    send0(b, 0, 0);
    check_rec0("after reset", {16'd64, 32'h2144DF1C, 4'b0000});

    // Randomized packets against the throttled instance.
    fork
      drv1();
      mon1();
    join
    @(negedge clk);
    check("rand pkt_count", 64'(pkt1), 64'(exp_pkt1));
    check("rand err_count", 64'(err1), 64'(exp_err1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
